// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_pkg
// Description : Shared definitions for the clock-enable generator: operating
//               mode encodings, step/run FSM state encoding and default widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package clk_pkg;

    // Operating modes presented on the debug switches; 2'b11 is reserved and
    // treated as HALT by the FSM.
    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    // Run/step controller states (explicit 2-bit encoding).
    typedef enum logic [1:0] {
        ST_HALT       = 2'd0,
        ST_RUN        = 2'd1,
        ST_STEP_IDLE  = 2'd2,
        ST_STEP_ARMED = 2'd3
    } state_t;

    // Default geometry of the generator.
    localparam int C_NUM_CH      = 2;
    localparam int C_DIV_W       = 16;
    localparam int C_DEFAULT_DIV = 1;
    localparam int C_CNT_W       = 32;

endpackage
`default_nettype wire

// File: rtl/clock_div_channel.sv
`default_nettype none
// ============================================================================
// Module      : clock_div_channel
// Description : One divided clock-enable channel. Counts active cycles and
//               emits a one-cycle enable every div_eff active cycles, toggling
//               a 50%-duty phase flag on each enable.
// Ports       : clk      - master clock
//               reset    - synchronous active-low reset
//               i_active - counting permitted this cycle
//               i_load   - latch i_ratio as the new divide ratio, clear counter
//               i_ratio  - new divide ratio (0 behaves as 1)
//               o_ce     - enable pulse
//               o_phase  - toggles on every enable (data only)
// Revision    : 1.0 - initial release
// ============================================================================
module clock_div_channel
    import clk_pkg::*;
#(
    parameter int DIV_W       = C_DIV_W,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_active,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_ratio,
    output logic             o_ce,
    output logic             o_phase
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_eff;
    logic             r_phase;

    // A zero ratio would never match; treat it as divide-by-one.
    assign w_div_eff = (r_div == '0) ? DIV_W'(1) : r_div;

    // Decoded from registered state only, so a load in this cycle still sees
    // the old ratio and counter.
    assign o_ce    = i_active && (r_cnt == (w_div_eff - DIV_W'(1)));
    assign o_phase = r_phase;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_div   <= DIV_W'(DEFAULT_DIV);
            r_phase <= 1'b0;
        end else if (i_load) begin
            // Load wins over counting; the phase flag is left untouched.
            r_div <= i_ratio;
            r_cnt <= '0;
        end else if (o_ce) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else if (i_active) begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : clock_enable_gen
// Description : Multi-channel clock-enable generator with run / halt /
//               single-step control. Channel 0 is the master: a step lasts
//               until exactly one ce[0] pulse, and cycle_count counts ce[0].
// Ports       : clk         - master clock
//               reset       - synchronous active-low reset
//               mode        - 00 HALT, 01 RUN, 10 STEP, 11 HALT
//               step_req    - step request level (rising edge used)
//               div_ratio   - per-channel ratios, channel i at [i*DIV_W +: DIV_W]
//               div_load    - per-channel ratio load strobes
//               ce          - per-channel enable pulses
//               phase       - per-channel 50% duty flags
//               running     - counters advancing this cycle
//               step_done   - one-cycle pulse after a completed step
//               cycle_count - number of ce[0] pulses
// Revision    : 1.0 - initial release
// ============================================================================
module clock_enable_gen
    import clk_pkg::*;
#(
    parameter int NUM_CH      = C_NUM_CH,
    parameter int DIV_W       = C_DIV_W,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV,
    parameter int CNT_W       = C_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    step_req,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic [NUM_CH-1:0]       div_load,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       phase,
    output logic                    running,
    output logic                    step_done,
    output logic [CNT_W-1:0]        cycle_count
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_step_req_prev;
    logic             w_step_edge;
    logic             w_active;
    logic             w_step_complete;
    logic             r_step_done;
    logic [CNT_W-1:0] r_cycle_count;

    assign w_active    = (r_state == ST_RUN) || (r_state == ST_STEP_ARMED);
    assign w_step_edge = step_req && !r_step_req_prev;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            clock_div_channel #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .i_active (w_active),
                .i_load   (div_load[i]),
                .i_ratio  (div_ratio[i*DIV_W +: DIV_W]),
                .o_ce     (ce[i]),
                .o_phase  (phase[i])
            );
        end
    endgenerate

    // Mode is checked first in every state, so leaving STEP while armed
    // aborts the step without a completion pulse.
    always_comb begin
        w_state_next    = r_state;
        w_step_complete = 1'b0;
        case (mode)
            MODE_RUN:  w_state_next = ST_RUN;
            MODE_HALT: w_state_next = ST_HALT;
            MODE_STEP: begin
                case (r_state)
                    ST_HALT, ST_RUN: w_state_next = ST_STEP_IDLE;
                    ST_STEP_IDLE: begin
                        if (w_step_edge) begin
                            w_state_next = ST_STEP_ARMED;
                        end
                    end
                    ST_STEP_ARMED: begin
                        // Further step edges here are dropped, not queued.
                        if (ce[0]) begin
                            w_state_next    = ST_STEP_IDLE;
                            w_step_complete = 1'b1;
                        end
                    end
                    default: w_state_next = ST_HALT;
                endcase
            end
            default:   w_state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= ST_HALT;
            r_step_req_prev <= 1'b0;
            r_step_done     <= 1'b0;
            r_cycle_count   <= '0;
        end else begin
            r_state         <= w_state_next;
            r_step_req_prev <= step_req;
            r_step_done     <= w_step_complete;
            r_cycle_count   <= r_cycle_count + {{(CNT_W-1){1'b0}}, ce[0]};
        end
    end

    assign running     = w_active;
    assign step_done   = r_step_done;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire
